// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator dispatcher.
// Contents:
//   FLOOR_W          width of the binary floor number reported by the car
//   UD_*             car command encodings carried on updown
//   FLOOR_MIN/MAX    lowest and highest valid floor numbers
//   ctrl_state_t     dispatcher FSM states
//   dir_t            sweep direction used for SCAN ordering
package elevator_pkg;

    localparam int FLOOR_W = 3;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [FLOOR_W-1:0] FLOOR_MIN = 3'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_MAX = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WAIT_FLOOR,
        OPEN_REQ,
        HOLD,
        CLOSE_REQ,
        FAULT
    } ctrl_state_t;

    typedef enum logic {
        UP,
        DOWN
    } dir_t;

endpackage

// File: rtl/elevator_call_register.sv
// Latched floor-call register with position-relative summaries.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   call_req     call buttons, bit i = floor i+1, OR-latched
//   floor        car's current floor (binary, 1-based)
//   clr_en       clear the current-floor bit this cycle (door is being held)
//   pending      latched, not-yet-served calls
//   here         a call is latched for the current floor
//   above/below  a call is latched for some floor above/below the current one
//   here_call    call_req is asserting the current floor's button right now
module elevator_call_register
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  clr_en,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  here,
    output logic                  above,
    output logic                  below,
    output logic                  here_call
);

    logic [NUM_FLOORS-1:0] pending_reg;
    logic [NUM_FLOORS-1:0] pending_next;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic [NUM_FLOORS-1:0] here_vec;
    logic [NUM_FLOORS-1:0] above_vec;
    logic [NUM_FLOORS-1:0] below_vec;
    logic [NUM_FLOORS-1:0] call_here_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            localparam logic [FLOOR_W-1:0] FL = FLOOR_W'(gi + 1);
            assign here_vec[gi]      = pending_reg[gi] && (floor == FL);
            assign above_vec[gi]     = pending_reg[gi] && (floor <  FL);
            assign below_vec[gi]     = pending_reg[gi] && (floor >  FL);
            assign call_here_vec[gi] = call_req[gi]    && (floor == FL);
            assign clr_vec[gi]       = clr_en          && (floor == FL);
        end
    endgenerate

    // The clear wins over a simultaneous press of the same floor, so a
    // call for the floor whose door is being held never gets latched.
    assign pending_next = (pending_reg | call_req) & ~clr_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending   = pending_reg;
    assign here      = |here_vec;
    assign above     = |above_vec;
    assign below     = |below_vec;
    assign here_call = |call_here_vec;

endmodule

// File: rtl/elevator_controller.sv
// Collective (SCAN) dispatcher driving the elevator car one floor per pulse.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   call_req   call buttons, bit i = floor i+1
//   floor      car's reported floor, 1..NUM_FLOORS valid
//   door       car door status, 1 = open
//   updown     car command: 00 stop, 01 up, 10 down (one-cycle pulses)
//   door_open  door request level to the car
//   pending    latched, unserved calls
//   fault      sticky error flag, cleared only by rst
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = int'(FLOOR_MAX),
    parameter int HOLD_CYCLES  = 20,
    parameter int MOVE_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  door,
    output logic [1:0]            updown,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  fault
);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE    = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS);

    ctrl_state_t          state_reg, state_next;
    dir_t                 dir_reg, dir_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [FLOOR_W-1:0]   target_reg, target_next;
    logic [FLOOR_W-1:0]   origin_reg, origin_next;
    logic [1:0]           updown_reg, updown_next;
    logic                 door_open_reg, door_open_next;
    logic                 fault_reg, fault_next;

    logic here, above, below, here_call;
    logic floor_ok;

    elevator_call_register #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_calls (
        .clk       (clk),
        .rst       (rst),
        .call_req  (call_req),
        .floor     (floor),
        .clr_en    (state_reg == HOLD),
        .pending   (pending),
        .here      (here),
        .above     (above),
        .below     (below),
        .here_call (here_call)
    );

    assign floor_ok = (floor >= FLOOR_MIN) && (floor <= TOP_FLOOR);

    always_comb begin
        state_next  = state_reg;
        dir_next    = dir_reg;
        cnt_next    = '0;
        target_next = target_reg;
        origin_next = origin_reg;

        if (state_reg != FAULT && !floor_ok) begin
            state_next = FAULT;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (door) begin
                        state_next = FAULT;
                    end else if (here) begin
                        state_next = OPEN_REQ;
                    end else if (dir_reg == UP) begin
                        if (above) begin
                            state_next = STEP;
                        end else if (below) begin
                            dir_next   = DOWN;
                            state_next = STEP;
                        end
                    end else begin
                        if (below) begin
                            state_next = STEP;
                        end else if (above) begin
                            dir_next   = UP;
                            state_next = STEP;
                        end
                    end
                end

                // The car latches the pulse at the end of this cycle, so the
                // floor seen here is still the departure floor.
                STEP: begin
                    origin_next = floor;
                    if (door) begin
                        state_next = FAULT;
                    end else if (dir_reg == UP) begin
                        target_next = floor + FLOOR_ONE;
                        state_next  = (floor >= TOP_FLOOR) ? FAULT : WAIT_FLOOR;
                    end else begin
                        target_next = floor - FLOOR_ONE;
                        state_next  = (floor <= FLOOR_MIN) ? FAULT : WAIT_FLOOR;
                    end
                end

                WAIT_FLOOR: begin
                    if (door) begin
                        state_next = FAULT;
                    end else if (floor == target_reg) begin
                        state_next = IDLE;
                    end else if (floor != origin_reg) begin
                        state_next = FAULT;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                OPEN_REQ: begin
                    if (door) begin
                        state_next = HOLD;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                // A fresh press of this floor restarts the hold; it takes
                // priority over the final hold cycle.
                HOLD: begin
                    if (here_call) begin
                        cnt_next = '0;
                    end else if (cnt_reg == HOLD_LAST) begin
                        state_next = CLOSE_REQ;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                CLOSE_REQ: begin
                    if (!door) begin
                        state_next = IDLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = FAULT;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                FAULT: begin
                    state_next = FAULT;
                end

                default: begin
                    state_next = FAULT;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so they
        // line up exactly with the state they belong to.
        updown_next    = UD_STOP;
        if (state_next == STEP) begin
            updown_next = (dir_next == UP) ? UD_UP : UD_DOWN;
        end
        door_open_next = (state_next == OPEN_REQ) || (state_next == HOLD);
        fault_next     = (state_next == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            dir_reg       <= UP;
            cnt_reg       <= '0;
            target_reg    <= '0;
            origin_reg    <= '0;
            updown_reg    <= UD_STOP;
            door_open_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            cnt_reg       <= cnt_next;
            target_reg    <= target_next;
            origin_reg    <= origin_next;
            updown_reg    <= updown_next;
            door_open_reg <= door_open_next;
            fault_reg     <= fault_next;
        end
    end

    assign updown    = updown_reg;
    assign door_open = door_open_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed testbench for elevator_controller with a simple behavioural car:
// the car moves one floor two falling edges after it sees a pulse, and its
// door follows door_open after two consecutive falling edges of disagreement.
module tb_elevator_controller;

    localparam logic [1:0] C_STOP = 2'b00;
    localparam logic [1:0] C_UP   = 2'b01;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] call_req;
    logic [2:0] floor;
    logic [1:0] updown;
    logic       door_open;
    logic [4:0] pending;
    logic       fault;

    // car model state
    logic [2:0] car_floor  = 3'd1;
    logic       car_door   = 1'b0;
    logic       car_ignore = 1'b0;
    int         move_cnt   = 0;
    logic       move_up    = 1'b0;
    int         door_cnt   = 0;

    // floor override for invalid-value injection
    logic       ovr_en  = 1'b0;
    logic [2:0] ovr_val = 3'd0;

    int up_total   = 0;
    int down_total = 0;
    int n_cmp      = 0;
    int n_mis      = 0;

    assign floor = ovr_en ? ovr_val : car_floor;

    always #5 clk = ~clk;

    elevator_controller dut (
        .clk       (clk),
        .rst       (rst),
        .call_req  (call_req),
        .floor     (floor),
        .door      (car_door),
        .updown    (updown),
        .door_open (door_open),
        .pending   (pending),
        .fault     (fault)
    );

    always @(negedge clk) begin
        if (move_cnt > 0) begin
            move_cnt = move_cnt - 1;
            if (move_cnt == 0) begin
                car_floor = move_up ? 3'(car_floor + 3'd1) : 3'(car_floor - 3'd1);
            end
        end else if (!car_ignore && updown != C_STOP) begin
            move_cnt = 2;
            move_up  = (updown == C_UP);
        end
        if (door_open != car_door) begin
            door_cnt = door_cnt + 1;
            if (door_cnt == 2) begin
                car_door = door_open;
                door_cnt = 0;
            end
        end else begin
            door_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (updown == 2'b01) up_total = up_total + 1;
        else if (updown == 2'b10) down_total = down_total + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] mask);
        call_req = mask;
        @(negedge clk);
        call_req = 5'b0;
    endtask

    task automatic wait_updown(input logic [1:0] exp, input string tag);
        int guard = 0;
        while (updown !== exp && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (updown !== exp) check_val(tag, 32'(updown), 32'(exp));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int guard = 0;
        while (!(pending == 5'b0 && door_open == 1'b0 && updown == C_STOP) && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        check_val(tag, 32'(guard < budget), 32'd1);
        tick(5);
    endtask

    // Measures how many falling edges door_open stays high; optionally
    // drives call_req=mask on the inject_at-th high edge and returns the
    // pending value seen one edge later.
    task automatic measure_door(input int inject_at, input logic [4:0] mask,
                                output int len, output logic [4:0] snap);
        int guard = 0;
        len  = 0;
        snap = 5'b0;
        while (door_open !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        while (door_open === 1'b1 && len < 400) begin
            len++;
            if (inject_at > 0 && len == inject_at + 1) snap = pending;
            call_req = (len == inject_at) ? mask : 5'b0;
            @(negedge clk);
        end
        call_req = 5'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int up0, dn0, len, k;
        logic [4:0] snap;

        rst = 1'b1;
        call_req = 5'b0;
        tick(3);
        rst = 1'b0;
        check_val("rst_updown", 32'(updown), 32'd0);
        check_val("rst_door_open", 32'(door_open), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);

        // floor 1 -> call 3: two up pulses, door cycle
        up0 = up_total; dn0 = down_total;
        press(5'b00100);
        check_val("t1_pending", 32'(pending), 32'b00100);
        tick(1);
        check_val("t1_pulse", 32'(updown), 32'(C_UP));
        tick(1);
        check_val("t1_pulse_len", 32'(updown), 32'(C_STOP));
        measure_door(0, 5'b0, len, snap);
        check_val("t1_door_len", 32'(len), 32'd22);
        wait_idle(400, "t1_settle");
        check_val("t1_ups", 32'(up_total - up0), 32'd2);
        check_val("t1_downs", 32'(down_total - dn0), 32'd0);
        check_val("t1_floor", 32'(floor), 32'd3);
        check_val("t1_pending_end", 32'(pending), 32'd0);

        // at 3 going up, calls 2 and 5: 5 first, then reverse to 2
        up0 = up_total; dn0 = down_total;
        press(5'b10010);
        check_val("t2_pending", 32'(pending), 32'b10010);
        tick(1);
        check_val("t2_first_dir", 32'(updown), 32'(C_UP));
        wait_idle(1500, "t2_settle");
        check_val("t2_ups", 32'(up_total - up0), 32'd2);
        check_val("t2_downs", 32'(down_total - dn0), 32'd3);
        check_val("t2_floor", 32'(floor), 32'd2);

        // go to 3, all buttons during hold cycle 15: hold restarts,
        // floor-3 bit never latched, remaining floors served in SCAN order
        up0 = up_total; dn0 = down_total;
        press(5'b00100);
        measure_door(18, 5'b11111, len, snap);
        check_val("t3_door_len", 32'(len), 32'd38);
        check_val("t3_pending_after_press", 32'(snap), 32'b11011);
        wait_idle(3000, "t3_settle");
        check_val("t3_ups", 32'(up_total - up0), 32'd3);
        check_val("t3_downs", 32'(down_total - dn0), 32'd4);
        check_val("t3_floor", 32'(floor), 32'd1);

        // car ignores the pulse: move timeout
        car_ignore = 1'b1;
        up0 = up_total; dn0 = down_total;
        press(5'b00010);
        wait_updown(C_UP, "t4_pulse_seen");
        k = 0;
        while (fault !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("t4_timeout_edges", 32'(k), 32'd65);
        check_val("t4_updown", 32'(updown), 32'd0);
        press(5'b10000);
        check_val("t4_pending_latch", 32'(pending), 32'b10010);
        tick(30);
        check_val("t4_ups", 32'(up_total - up0), 32'd1);
        check_val("t4_downs", 32'(down_total - dn0), 32'd0);
        check_val("t4_fault_sticky", 32'(fault), 32'd1);
        check_val("t4_door_open", 32'(door_open), 32'd0);

        // invalid floor value while idle
        car_ignore = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_val("t5_rst_fault", 32'(fault), 32'd0);
        check_val("t5_rst_pending", 32'(pending), 32'd0);
        ovr_val = 3'd6;
        ovr_en  = 1'b1;
        tick(1);
        check_val("t5_invalid_fault", 32'(fault), 32'd1);
        rst    = 1'b1;
        ovr_en = 1'b0;
        tick(1);
        rst = 1'b0;
        check_val("t5_clr_fault", 32'(fault), 32'd0);
        check_val("t5_clr_pending", 32'(pending), 32'd0);
        check_val("t5_clr_updown", 32'(updown), 32'd0);
        check_val("t5_clr_door_open", 32'(door_open), 32'd0);

        // reset right after an up pulse toward floor 5
        tick(2);
        up0 = up_total; dn0 = down_total;
        press(5'b10000);
        check_val("t6_pending", 32'(pending), 32'b10000);
        wait_updown(C_UP, "t6_pulse_seen");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_val("t6_pending_clr", 32'(pending), 32'd0);
        check_val("t6_updown", 32'(updown), 32'd0);
        tick(20);
        check_val("t6_ups", 32'(up_total - up0), 32'd1);
        check_val("t6_downs", 32'(down_total - dn0), 32'd0);
        check_val("t6_floor", 32'(floor), 32'd2);
        check_val("t6_fault", 32'(fault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
